dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Requester-side controller that drives the word-wide data memory (combinational read, write on clock edge).
- Accepts CPU load/store requests of byte, halfword or word size and turns each one into a sequence of word-memory cycles. Sub-word stores use read-modify-write.
- Extracts and sign- or zero-extends load data, and reports misaligned or out-of-range accesses as errors.
- Sits between the CPU memory stage and the data memory.

Parameters:
- ADDR_BITS, 10, word-index width; the data memory holds 2**ADDR_BITS words.
- DATA_W, 32, word width; fixed at 32, not to be overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; the block is in reset while reset==0.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=halfword, 2=word; 3 is illegal.
- req_sign  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; no memory write occurred.
- mem_addr  out  ADDR_BITS  word index, equal to latched addr[ADDR_BITS+1:2].
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. A halfword at addr[1]=h occupies bits [16h+15:16h].
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- In reset: state=IDLE; all registered outputs 0; mem_we=0 immediately (async); any in-flight operation is abandoned with no write.
- req_ready=1 only in IDLE and when reset is deasserted. Requests presented in any other state are ignored (not queued).
- Acceptance: req_valid && req_ready at a rising edge latches we, size, sign, addr and wdata. All later cycles use only the latched copies.
- An accepted request is an error if any of the following hold; it then goes to RESP with resp_err=1 and performs no memory cycle:
  - size==3;
  - halfword with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_BITS+2]!=0.
- Otherwise the next state is:
  - load -> LOAD;
  - word store -> WRITE;
  - byte or halfword store -> RMW_RD.
- LOAD (1 cycle): mem_addr valid. At the edge, resp_rdata is registered with the selected lane extended per the latched sign (size word ignores sign). -> RESP.
- RMW_RD (1 cycle): the edge captures mem_rd into a merge buffer, with the target lane(s) replaced by req_wdata[7:0] or [15:0]. Other lanes are preserved bit-exact. -> WRITE.
- WRITE (1 cycle): mem_we=1. mem_wd is the merge buffer (sub-word) or latched wdata (word). -> RESP.
- RESP (1 cycle): resp_valid=1; resp_err and resp_rdata held. -> IDLE. Outputs clear to 0 on leaving RESP.
- mem_we is high only in WRITE, for exactly one cycle per store.
- mem_addr and mem_wd are don't-care outside LOAD, RMW_RD and WRITE, but must be stable within each state.
- Latency, from the accept edge to the resp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back: a new request can be accepted in the cycle after RESP. Throughput is one request per 3 cycles for loads and word stores, and one per 4 cycles for sub-word stores.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF -> one mem_we pulse with mem_addr=4, mem_wd=0xDEADBEEF, resp_valid 2 cycles after accept. Load word 0x10 -> resp_rdata=0xDEADBEEF.
- Sub-word RMW: memory word 4 = 0x11223344; store byte 0x13 with wdata 0xAB -> mem_wd=0xAB223344, resp 3 cycles after accept. Store halfword 0x10 with wdata 0xCDEF -> word becomes 0xAB22CDEF.
- Load extension on word 0x8000FF7F at addr 0x20:
  - lb 0x21, sign=1 -> 0xFFFFFFFF;
  - lbu 0x20 -> 0x0000007F;
  - lh 0x22, sign=1 -> 0xFFFF8000;
  - lhu 0x22 -> 0x00008000.
- Errors, each giving resp_err=1, resp_valid 1 cycle after accept, mem_we never high:
  - halfword at 0x11;
  - word at 0x12;
  - size=3;
  - addr 0x00001000 with ADDR_BITS=10.
- Handshake: hold req_valid high continuously with distinct requests -> each accepted only when req_ready=1, none lost or duplicated, and resp_valid is a single-cycle pulse per request.
- Reset mid-operation: assert reset (drive low) during RMW_RD of a byte store -> mem_we never pulses, memory unchanged, outputs 0 asynchronously. After release, a load of the same word returns its original value.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// CPU-request / response / data-memory bundle for dm_access_ctrl.
// A request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle completion pulse.
interface dm_access_ctrl_if #(
  parameter int ADDR_BITS = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_sign;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_we;
  logic [31:0]          mem_wd;
  logic [31:0]          mem_rd;
  logic [2:0]           dbg_state;

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd,
           dbg_state
  );

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd,
           dbg_state
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Turns byte/halfword/word CPU loads and stores into word-memory cycles,
// using read-modify-write for sub-word stores and extending load data.
module dm_access_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  dm_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   req_err;
  logic                   we_q;
  logic [1:0]             size_q;
  logic                   sign_q;
  logic [ADDR_BITS+1:0]   addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      merge_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   err_q;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic [DATA_W-1:0]      load_ext;
  logic [DATA_W-1:0]      merged;

  assign accept = bus.req_valid && (state == IDLE);

  // Error decode uses the live request: it only matters on the accept edge.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'd3)                                 req_err = 1'b1;
    if (bus.req_size == 2'd1 && bus.req_addr[0])              req_err = 1'b1;
    if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)   req_err = 1'b1;
    if (bus.req_addr[31:ADDR_BITS+2] != '0)                   req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_nxt = RESP;
          else if (!bus.req_we)         state_nxt = LOAD;
          else if (bus.req_size == 2'd2) state_nxt = WRITE;
          else                          state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE) && reset;
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.mem_addr   = addr_q[ADDR_BITS+1:2];
    bus.mem_we     = (state == WRITE);
    bus.mem_wd     = (size_q == 2'd2) ? wdata_q : merge_q;
    bus.dbg_state  = state;
  end

  // Lane extraction and merge both key off the latched address.
  always_comb begin
    lane_b   = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    load_ext = bus.mem_rd;
    case (size_q)
      2'd0:    load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
      2'd1:    load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_rd;
    endcase
    merged = bus.mem_rd;
    if (size_q == 2'd0) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        sign_q  <= bus.req_sign;
        addr_q  <= bus.req_addr[ADDR_BITS+1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == LOAD && !we_q) rdata_q <= load_ext;
      if (state == RMW_RD)        merge_q <= merged;
      if (state == RESP) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Table-driven bench for dm_access_ctrl with a behavioural word memory,
// plus hand sequences for continuous-valid handshaking and mid-operation reset.
module tb_dm_access_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] mem [0:1023];
  logic [31:0] exp_q [$];

  dm_access_ctrl_if #(.ADDR_BITS(10)) bus ();

  dm_access_ctrl #(.ADDR_BITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vq [$];

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int wes, output logic [31:0] wd, output logic [9:0] wa,
                        output logic post_rv, output logic [31:0] post_rdata);
    int g;
    rdata = 'x; err = 1'bx; lat = -1; wes = 0; wd = 'x; wa = 'x;
    @(negedge clk);
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        wes++;
        wd = bus.mem_wd;
        wa = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        lat   = k;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    post_rv    = bus.resp_valid;
    post_rdata = bus.resp_rdata;
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [31:0] rdata, wd, post_rdata;
    logic        err, post_rv;
    logic [9:0]  wa;
    int          lat, wes;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready",      {31'b0, bus.req_ready},  32'h0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("rst_mem_we",     {31'b0, bus.mem_we},     32'h0);
    check("rst_rdata",      bus.resp_rdata,          32'h0);
    check("rst_err",        {31'b0, bus.resp_err},   32'h0);
    check("rst_state",      {29'b0, bus.dbg_state},  32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready",     {31'b0, bus.req_ready},  32'h1);

    //                 we  sz  sg  addr          wdata         rdata         err lat wes wd
    vq.push_back(vec_t'{1, 2'd2, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd2, 0, 32'h10,       32'h11223344, 32'h0,        0, 2, 1, 32'h11223344});
    vq.push_back(vec_t'{1, 2'd0, 0, 32'h13,       32'h000000AB, 32'h0,        0, 3, 1, 32'hAB223344});
    vq.push_back(vec_t'{1, 2'd1, 0, 32'h10,       32'h0000CDEF, 32'h0,        0, 3, 1, 32'hAB22CDEF});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'h10,       32'h0,        32'hAB22CDEF, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd2, 0, 32'h20,       32'h8000FF7F, 32'h0,        0, 2, 1, 32'h8000FF7F});
    vq.push_back(vec_t'{0, 2'd0, 1, 32'h21,       32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd0, 0, 32'h20,       32'h0,        32'h0000007F, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd1, 1, 32'h22,       32'h0,        32'hFFFF8000, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd1, 0, 32'h22,       32'h0,        32'h00008000, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd0, 1, 32'h20,       32'h0,        32'h0000007F, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd0, 0, 32'h23,       32'h0,        32'h00000080, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd2, 1, 32'h20,       32'h0,        32'h8000FF7F, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd1, 0, 32'h11,       32'h0000FFFF, 32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'h12,       32'h0,        32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd2, 0, 32'h12,       32'h12345678, 32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd3, 0, 32'h10,       32'h0,        32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'h1000,     32'h0,        32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd2, 0, 32'h1000,     32'hCAFEF00D, 32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd0, 0, 32'h80000010, 32'h00000055, 32'h0,        1, 1, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'h10,       32'h0,        32'hAB22CDEF, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'h0,        32'h0,        32'h0,        0, 2, 0, 32'h0});
    vq.push_back(vec_t'{1, 2'd2, 0, 32'hFFC,      32'h0BADF00D, 32'h0,        0, 2, 1, 32'h0BADF00D});
    vq.push_back(vec_t'{0, 2'd2, 0, 32'hFFC,      32'h0,        32'h0BADF00D, 0, 2, 0, 32'h0});
    vq.push_back(vec_t'{0, 2'd1, 1, 32'hFFC,      32'h0,        32'hFFFFF00D, 0, 2, 0, 32'h0});

    foreach (vq[i]) begin
      do_req(vq[i].we, vq[i].size, vq[i].sign, vq[i].addr, vq[i].wdata,
             rdata, err, lat, wes, wd, wa, post_rv, post_rdata);
      check($sformatf("v%0d_rdata", i), rdata, vq[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vq[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, vq[i].exp_lat);
      check($sformatf("v%0d_we_pulses", i), wes, vq[i].exp_wes);
      check($sformatf("v%0d_post_rv", i), {31'b0, post_rv}, 32'h0);
      check($sformatf("v%0d_post_rdata", i), post_rdata, 32'h0);
      if (vq[i].exp_wes != 0) begin
        check($sformatf("v%0d_mem_wd", i), wd, vq[i].exp_wd);
        check($sformatf("v%0d_mem_addr", i), {22'b0, wa}, {22'b0, vq[i].addr[11:2]});
      end
    end

    // continuous req_valid with distinct requests
    begin
      vec_t hs [4];
      int   idx, nresp, cyc;
      logic prev_rv, acc;
      mem[64] = 32'hA5A50001;
      mem[65] = 32'h01020304;
      hs[0] = vec_t'{0, 2'd2, 0, 32'h100, 32'h0,  32'hA5A50001, 0, 0, 0, 32'h0};
      hs[1] = vec_t'{1, 2'd0, 0, 32'h105, 32'h5A, 32'h0,        0, 0, 0, 32'h0};
      hs[2] = vec_t'{0, 2'd2, 0, 32'h104, 32'h0,  32'h01025A04, 0, 0, 0, 32'h0};
      hs[3] = vec_t'{0, 2'd1, 0, 32'h102, 32'h0,  32'h0000A5A5, 0, 0, 0, 32'h0};
      foreach (hs[i]) exp_q.push_back(hs[i].exp_rdata);
      @(negedge clk);
      idx = 0; nresp = 0; cyc = 0; prev_rv = 1'b0; acc = 1'b0;
      bus.req_we = hs[0].we; bus.req_size = hs[0].size; bus.req_sign = hs[0].sign;
      bus.req_addr = hs[0].addr; bus.req_wdata = hs[0].wdata; bus.req_valid = 1'b1;
      while (cyc < 60 && (nresp < 4 || cyc < 30)) begin
        if (bus.resp_valid) begin
          check("hs_single_pulse", {31'b0, prev_rv}, 32'h0);
          if (exp_q.size() == 0) check("hs_extra_resp", nresp + 1, 4);
          else check($sformatf("hs_resp%0d", nresp), bus.resp_rdata, exp_q.pop_front());
          nresp++;
        end
        prev_rv = bus.resp_valid;
        if (acc) begin
          idx++;
          if (idx < 4) begin
            bus.req_we = hs[idx].we; bus.req_size = hs[idx].size; bus.req_sign = hs[idx].sign;
            bus.req_addr = hs[idx].addr; bus.req_wdata = hs[idx].wdata;
          end else begin
            bus.req_valid = 1'b0;
          end
        end
        acc = bus.req_ready && bus.req_valid;
        @(negedge clk);
        cyc++;
      end
      bus.req_valid = 1'b0;
      check("hs_resp_count", nresp, 4);
      check("hs_accept_count", idx, 4);
      check("hs_queue_empty", exp_q.size(), 0);
      check("hs_mem65", mem[65], 32'h01025A04);
    end

    // reset asserted during RMW_RD of a byte store
    begin
      int wcnt;
      mem[80] = 32'h11223344;
      @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_sign = 1'b0;
      bus.req_addr = 32'h141; bus.req_wdata = 32'hEE; bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("rmw_state", {29'b0, bus.dbg_state}, 32'h2);
      #2 reset = 1'b0;
      #1;
      check("arst_mem_we",     {31'b0, bus.mem_we},     32'h0);
      check("arst_state",      {29'b0, bus.dbg_state},  32'h0);
      check("arst_ready",      {31'b0, bus.req_ready},  32'h0);
      check("arst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("arst_rdata",      bus.resp_rdata,          32'h0);
      wcnt = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.mem_we) wcnt++;
      end
      check("arst_no_write", wcnt, 0);
      reset = 1'b1;
      check("arst_mem_intact", mem[80], 32'h11223344);
      do_req(1'b0, 2'd2, 1'b0, 32'h140, 32'h0, rdata, err, lat, wes, wd, wa, post_rv, post_rdata);
      check("arst_reload", rdata, 32'h11223344);
      check("arst_reload_err", {31'b0, err}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
